// File: rtl/cam_frame_serializer.sv
// Serializes one frame of FRAME_PIXELS pixels onto a single-bit camera line: start bit, then data MSB first.
// Define CAM_SER_PARITY_EN to append an even-parity bit after each pixel's data bits.
module cam_frame_serializer #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 784,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_frame_start,
  input  logic [PIX_W-1:0]                  i_pix_data,
  input  logic                              i_pix_valid,
  output logic                              o_pix_ready,
  output logic                              o_cam_data,
  output logic                              o_busy,
  output logic                              o_frame_done,
  output logic [$clog2(FRAME_PIXELS+1)-1:0] o_pix_count,
  output logic                              o_underflow
);

  localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(PIX_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_PIXELS);

`ifdef CAM_SER_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_END    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_END   = 3'd5
  } state_t;
`endif

  function automatic logic even_parity(input logic [PIX_W-1:0] data);
    return ^data;
  endfunction

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIX_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               under_q, under_d;
  logic               ready_q, ready_d;
  logic               cam_q, cam_d;
  logic               fetch_first_q, fetch_first_d;
  logic               end_s;

  // Next-state, bit timing, pixel counting and underflow detection
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    under_d = under_q;
    end_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_frame_start) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          count_d = CNT_ZERO;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_FETCH: begin
        tick_d = TICK_ZERO;
        if (i_pix_valid) begin
          shift_d = i_pix_data;
          state_d = ST_START;
        end else if ((count_q != CNT_ZERO) && !fetch_first_q) begin
          // The first fetch cycle of a later pixel is free; any further wait is a stall
          under_d = 1'b1;
        end else begin
          under_d = under_q;
        end
      end
      ST_START: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = TICK_ZERO;
          idx_d   = IDX_MSB;
          state_d = ST_DATA;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d = TICK_ZERO;
          if (idx_q == IDX_ZERO) begin
`ifdef CAM_SER_PARITY_EN
            state_d = ST_PARITY;
`else
            end_s = 1'b1;
`endif
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
`ifdef CAM_SER_PARITY_EN
      ST_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = TICK_ZERO;
          end_s  = 1'b1;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
`endif
      ST_END: begin
        if (count_q == CNT_FULL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (end_s) begin
      state_d = ST_END;
      count_d = count_q + CNT_ONE;
      if (count_d == CNT_FULL) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Line and handshake outputs precomputed from the next state so they leave flops
  always_comb begin
    ready_d       = (state_d == ST_FETCH);
    fetch_first_d = ready_d && (state_q != ST_FETCH);
    case (state_d)
      ST_START:  cam_d = 1'b1;
      ST_DATA:   cam_d = shift_d[idx_d];
`ifdef CAM_SER_PARITY_EN
      ST_PARITY: cam_d = even_parity(shift_d);
`endif
      default:   cam_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      tick_q        <= TICK_ZERO;
      idx_q         <= IDX_ZERO;
      shift_q       <= {PIX_W{1'b0}};
      count_q       <= CNT_ZERO;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      under_q       <= 1'b0;
      ready_q       <= 1'b0;
      cam_q         <= 1'b0;
      fetch_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      under_q       <= under_d;
      ready_q       <= ready_d;
      cam_q         <= cam_d;
      fetch_first_q <= fetch_first_d;
    end
  end

  assign o_pix_ready  = ready_q;
  assign o_cam_data   = cam_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_pix_count  = count_q;
  assign o_underflow  = under_q;

endmodule

// File: tb/tb_cam_frame_serializer.sv
// Randomized bench for cam_frame_serializer: a per-cycle line/status trace is built from the
// line format rules for each frame and compared against the DUT every cycle.
module tb_cam_frame_serializer;

  localparam int PIX_W = 8;
  localparam int N     = 6;
  localparam int C     = 4;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_frame_start;
  logic [PIX_W-1:0] i_pix_data;
  logic             i_pix_valid;
  logic             o_pix_ready;
  logic             o_cam_data;
  logic             o_busy;
  logic             o_frame_done;
  logic [CNT_W-1:0] o_pix_count;
  logic             o_underflow;

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] pix [N];
  int               gap [N];
  bit               model_und;
  bit               final_und;
  int               data3_idx;

  bit q_cam[$];
  bit q_busy[$];
  bit q_done[$];
  bit q_und[$];
  int q_cnt[$];

  always #5 clk = ~clk;

  cam_frame_serializer #(
    .PIX_W(PIX_W),
    .FRAME_PIXELS(N),
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_frame_start(i_frame_start),
    .i_pix_data(i_pix_data),
    .i_pix_valid(i_pix_valid),
    .o_pix_ready(o_pix_ready),
    .o_cam_data(o_cam_data),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_pix_count(o_pix_count),
    .o_underflow(o_underflow)
  );

  task automatic push(input bit cam, input bit busy, input bit done, input int cnt, input bit und);
    q_cam.push_back(cam);
    q_busy.push_back(busy);
    q_done.push_back(done);
    q_cnt.push_back(cnt);
    q_und.push_back(und);
  endtask

  // Expected cycle-by-cycle behaviour of a frame, starting with the cycle after the start pulse.
  task automatic build_trace();
    bit und;
    q_cam.delete(); q_busy.delete(); q_done.delete(); q_cnt.delete(); q_und.delete();
    und = model_und;
    data3_idx = -1;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i <= gap[k]; i++) begin
        push(1'b0, 1'b1, 1'b0, k, und);
        if (k > 0 && i >= 1 && i < gap[k]) und = 1'b1;
      end
      for (int t = 0; t < C; t++) push(1'b1, 1'b1, 1'b0, k, und);
      if (k == 3) data3_idx = q_cam.size();
      for (int b = PIX_W - 1; b >= 0; b--)
        for (int t = 0; t < C; t++) push(pix[k][b], 1'b1, 1'b0, k, und);
`ifdef CAM_SER_PARITY_EN
      for (int t = 0; t < C; t++) push(^pix[k], 1'b1, 1'b0, k, und);
`endif
      push(1'b0, (k + 1 < N), (k + 1 == N), k + 1, und);
    end
    push(1'b0, 1'b0, 1'b0, N, und);
    final_und = und;
  endtask

  // Runs one frame from a negedge; optionally aborts with reset during DATA of pixel 3.
  task automatic run_frame(input string name, input bit abort, input bit b2b);
    int k;
    int gap_left;
    int abort_at;
    int len;
    build_trace();
    len = q_cam.size();
    abort_at = abort ? data3_idx + 5 : -1;
    i_frame_start = 1'b1;
    i_pix_valid   = 1'($urandom_range(0, 1));
    i_pix_data    = PIX_W'($urandom);
    k = 0;
    gap_left = gap[0];
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      checks++;
      if (o_cam_data !== q_cam[j]) begin
        errors++;
        $display("FAIL %s cam_data cyc %0d: got %b expected %b", name, j, o_cam_data, q_cam[j]);
      end
      checks++;
      if (o_busy !== q_busy[j]) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b expected %b", name, j, o_busy, q_busy[j]);
      end
      checks++;
      if (o_frame_done !== q_done[j]) begin
        errors++;
        $display("FAIL %s frame_done cyc %0d: got %b expected %b", name, j, o_frame_done, q_done[j]);
      end
      checks++;
      if (o_pix_count !== CNT_W'(q_cnt[j])) begin
        errors++;
        $display("FAIL %s pix_count cyc %0d: got %0d expected %0d", name, j, o_pix_count, q_cnt[j]);
      end
      checks++;
      if (o_underflow !== q_und[j]) begin
        errors++;
        $display("FAIL %s underflow cyc %0d: got %b expected %b", name, j, o_underflow, q_und[j]);
      end
      if (j == abort_at) begin
        i_rst = 1'b1;
        i_frame_start = 1'b0;
        i_pix_valid = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        checks++;
        if ({o_busy, o_cam_data, o_frame_done, o_pix_ready, o_underflow} !== 5'b00000 ||
            o_pix_count !== CNT_W'(0)) begin
          errors++;
          $display("FAIL %s abort: got busy=%b cam=%b done=%b ready=%b und=%b cnt=%0d expected all 0",
                   name, o_busy, o_cam_data, o_frame_done, o_pix_ready, o_underflow, o_pix_count);
        end
        model_und = 1'b0;
        return;
      end
      if (j + 1 <= len - 2)
        i_frame_start = (b2b && (j + 1 == len - 2)) ? 1'b1 : ($urandom_range(0, 7) == 0);
      else
        i_frame_start = 1'b0;
      if (o_pix_ready === 1'b1 && k < N) begin
        if (gap_left > 0) begin
          i_pix_valid = 1'b0;
          i_pix_data  = PIX_W'($urandom);
          gap_left--;
        end else begin
          i_pix_valid = 1'b1;
          i_pix_data  = pix[k];
          k++;
          gap_left = (k < N) ? gap[k] : 0;
        end
      end else begin
        i_pix_valid = 1'($urandom_range(0, 1));
        i_pix_data  = PIX_W'($urandom);
      end
    end
    i_frame_start = 1'b0;
    model_und = final_und;
  endtask

  task automatic fill(input int first_gap_max, input int gap_max);
    for (int k = 0; k < N; k++) begin
      pix[k] = PIX_W'($urandom);
      gap[k] = (k == 0) ? $urandom_range(0, first_gap_max) : $urandom_range(0, gap_max);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_frame_start = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_cam_data, o_pix_ready, o_busy, o_frame_done, o_underflow} !== 5'b00000 ||
        o_pix_count !== CNT_W'(0)) begin
      errors++;
      $display("FAIL reset: got cam=%b ready=%b busy=%b done=%b und=%b cnt=%0d expected all 0",
               o_cam_data, o_pix_ready, o_busy, o_frame_done, o_underflow, o_pix_count);
    end
    model_und = 1'b0;
  endtask

  task automatic test_idle_valid();
    i_pix_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_pix_data = PIX_W'($urandom);
      @(negedge clk);
      checks++;
      if (o_pix_ready !== 1'b0 || o_busy !== 1'b0 || o_pix_count !== CNT_W'(0)) begin
        errors++;
        $display("FAIL idle_valid cyc %0d: got ready=%b busy=%b cnt=%0d expected 0 0 0",
                 i, o_pix_ready, o_busy, o_pix_count);
      end
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic test_pattern_a5();
    fill(0, 0);
    pix[0] = 8'hA5;
    run_frame("pattern_a5", 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      fill(5, 1);
      run_frame("random", 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    fill(0, 0);
    run_frame("b2b_first", 1'b0, 1'b1);
    fill(0, 0);
    run_frame("b2b_second", 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    fill(0, 0);
    gap[5] = 10;
    run_frame("underflow", 1'b0, 1'b0);
    fill(0, 0);
    run_frame("underflow_sticky", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    fill(0, 0);
    run_frame("abort", 1'b1, 1'b0);
    fill(0, 0);
    run_frame("restart", 1'b0, 1'b0);
  endtask

`ifdef CAM_SER_PARITY_EN
  task automatic test_parity();
    fill(0, 0);
    pix[0] = 8'h07;
    pix[1] = 8'h03;
    run_frame("parity", 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_idle_valid();
    test_pattern_a5();
    test_random_frames();
    test_back_to_back();
    test_underflow();
    test_reset_mid_frame();
`ifdef CAM_SER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
